dvp_camera_emulator: RTL

- Synthetic OV7670-style DVP camera source. It drives pclk, href, vsync and RGB565 bytes with the same timing a real camera sensor presents to the FPGA capture path.
- Its outputs connect where the sensor's cam_pclk/cam_href/cam_vsync/cam_data would, so capture logic can be brought up and regressed without the sensor.
- It generates selectable test patterns, runs continuously while enabled, and reports frame completion and a frame count.

---
 rtl/dvp_camera_emulator.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/dvp_camera_emulator.sv
// Synthetic OV7670-style DVP source that drives pclk, href, vsync and RGB565 bytes
// with sensor-like frame timing and selectable test patterns.
module dvp_camera_emulator #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        cam_pclk,
  output logic        cam_href,
  output logic        cam_vsync,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int unsigned LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
  localparam int unsigned HREF_BYTES = 2 * H_ACTIVE;
  localparam int unsigned BAR_W      = H_ACTIVE / 8;
  localparam int unsigned M1         = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned M2         = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int unsigned MAX_LINES  = (M1 > M2) ? M1 : M2;
  localparam int unsigned HW         = $clog2(LINE_BYTES);
  localparam int unsigned LW         = $clog2(MAX_LINES + 1);
  localparam int unsigned XW         = $clog2(H_ACTIVE);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t          state, state_n;
  logic [HW-1:0]   hcnt, hcnt_n;
  logic [LW-1:0]   lcnt, lcnt_n, last_line;
  logic            line_end, start_frame, active_end;
  logic [1:0]      pattern_q;
  logic [15:0]     solid_q;
  logic [15:0]     pixel;
  logic [XW-1:0]   x;

  // Register stage: pclk divider every clk; frame state only advances on pclk falling edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      cam_pclk    <= 1'b0;
      state       <= IDLE;
      hcnt        <= '0;
      lcnt        <= '0;
      pattern_q   <= '0;
      solid_q     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      cam_pclk   <= ~cam_pclk;
      frame_done <= 1'b0;
      if (cam_pclk) begin
        state <= state_n;
        hcnt  <= hcnt_n;
        lcnt  <= lcnt_n;
        if (start_frame) begin
          pattern_q <= pattern_sel;
          solid_q   <= frame_count;
        end
        if (active_end) begin
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

  // Next-state logic: byte counter within a line, line counter within the current state.
  always_comb begin
    state_n     = state;
    hcnt_n      = hcnt;
    lcnt_n      = lcnt;
    start_frame = 1'b0;
    active_end  = 1'b0;
    line_end    = (32'(hcnt) == LINE_BYTES - 1);
    last_line   = '0;
    case (state)
      VSYNC:   last_line = LW'(VSYNC_LINES - 1);
      VBACK:   last_line = LW'(V_BACK - 1);
      ACTIVE:  last_line = LW'(V_ACTIVE - 1);
      VFRONT:  last_line = LW'(V_FRONT - 1);
      default: last_line = '0;
    endcase
    if (state == IDLE) begin
      if (enable) begin
        state_n     = VSYNC;
        hcnt_n      = '0;
        lcnt_n      = '0;
        start_frame = 1'b1;
      end
    end else begin
      hcnt_n = line_end ? '0 : hcnt + HW'(1);
      if (line_end) begin
        if (lcnt == last_line) begin
          lcnt_n = '0;
          case (state)
            VSYNC:   state_n = VBACK;
            VBACK:   state_n = ACTIVE;
            ACTIVE: begin
              state_n    = VFRONT;
              active_end = 1'b1;
            end
            default: begin
              if (enable) begin
                state_n     = VSYNC;
                start_frame = 1'b1;
              end else begin
                state_n = IDLE;
              end
            end
          endcase
        end else begin
          lcnt_n = lcnt + LW'(1);
        end
      end
    end
  end

  // Pattern generator: pixel value for the current x (byte pair) and y (active line).
  always_comb begin
    x     = XW'(hcnt >> 1);
    pixel = '0;
    case (pattern_q)
      2'd0: begin
        case (3'(32'(x) / BAR_W))
          3'd0:    pixel = 16'hFFFF;
          3'd1:    pixel = 16'hFFE0;
          3'd2:    pixel = 16'h07FF;
          3'd3:    pixel = 16'h07E0;
          3'd4:    pixel = 16'hF81F;
          3'd5:    pixel = 16'hF800;
          3'd6:    pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd1:    pixel = 16'(x);
      2'd2:    pixel = (((32'(x) ^ 32'(lcnt)) & 32'd8) != 32'd0) ? 16'hFFFF : 16'h0000;
      default: pixel = solid_q;
    endcase
  end

  // Sync and data decode from registered state, so outputs move only with pclk falling edges.
  always_comb begin
    cam_vsync = (state == VSYNC);
    cam_href  = (state == ACTIVE) && (32'(hcnt) < HREF_BYTES);
    cam_data  = '0;
    if (cam_href) begin
      cam_data = hcnt[0] ? pixel[7:0] : pixel[15:8];
    end
  end

endmodule
